updown_count_sync_reset: RTL and testbench

UPDOWN_COUNT_SYNC_RESET -- requirements
Module: updown_count_sync_reset

---
 rtl/updown_count_sync_reset.sv | 105 ++++++++++
 tb/tb_updown_count_sync_reset.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/updown_count_sync_reset.sv
// Up/down counter with bound, saturate-or-wrap, load and enable prescaler.
// Optional sticky wrap_flag with wrap_clr when UPDOWN_COUNT_WRAP_FLAG_EN is defined.
module updown_count_sync_reset #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter int unsigned      DIV     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
    input  logic             wrap_clr,
    output logic             wrap_flag,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    logic             step_c;
    logic             step_wraps_c;
    logic [WIDTH-1:0] step_cnt_c;
    logic [WIDTH-1:0] load_clamp_c;

    // Prescaler: a count step fires on the enabled cycle that closes a DIV-cycle group.
    generate
        if (DIV > 1) begin : g_psc
            localparam int unsigned PSC_W = $clog2(DIV);
            logic [PSC_W-1:0] psc;
            logic             psc_last_c;

            assign psc_last_c = (psc == PSC_W'(DIV - 1));
            assign step_c     = en && psc_last_c;

            always_ff @(posedge clk) begin
                if (reset || load) begin
                    psc <= '0;
                end else if (en) begin
                    psc <= psc_last_c ? '0 : psc + PSC_W'(1);
                end
            end
        end else begin : g_no_psc
            assign step_c = en;
        end
    endgenerate

    // Next count for a step, and whether that step crosses the bound.
    always_comb begin
        load_clamp_c = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        step_cnt_c   = cnt;
        step_wraps_c = 1'b0;
        if (up) begin
            if (cnt < MAX_VAL) begin
                step_cnt_c = cnt + WIDTH'(1);
            end else if (sat) begin
                step_cnt_c = MAX_VAL;
            end else begin
                step_cnt_c   = '0;
                step_wraps_c = 1'b1;
            end
        end else begin
            if (cnt > '0) begin
                step_cnt_c = cnt - WIDTH'(1);
            end else if (!sat) begin
                step_cnt_c   = MAX_VAL;
                step_wraps_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= load_clamp_c;
            wrap <= 1'b0;
        end else begin
            wrap <= step_c && step_wraps_c;
            if (step_c) begin
                cnt <= step_cnt_c;
            end
        end
    end

    assign tc = up ? (cnt == MAX_VAL) : (cnt == '0);

`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
    // Sticky wrap indicator; a wrap in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_flag <= 1'b0;
        end else if (!load && step_c && step_wraps_c) begin
            wrap_flag <= 1'b1;
        end else if (wrap_clr) begin
            wrap_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_updown_count_sync_reset.sv
// Scoreboard bench for updown_count_sync_reset: a DIV=1 and a DIV=3 instance,
// both WIDTH=4 / MAX_VAL=9, driven from shared inputs.
module tb_updown_count_sync_reset;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       wrap;
        logic       flag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] cnt1, cnt3;
    logic       tc1, tc3, wrap1, wrap3;
`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
    logic       wrap_clr = 1'b0;
    logic       flag1, flag3;
`endif

    exp_t q1[$];
    exp_t q3[$];
    int   total = 0;
    int   bad   = 0;

    bit         en_seq [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    logic [3:0] cnt_seq[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};

    always #5 clk = ~clk;

    updown_count_sync_reset #(.WIDTH(4), .MAX_VAL(4'd9), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
        .wrap_clr(wrap_clr), .wrap_flag(flag1),
`endif
        .cnt(cnt1), .tc(tc1), .wrap(wrap1)
    );

    updown_count_sync_reset #(.WIDTH(4), .MAX_VAL(4'd9), .DIV(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
        .wrap_clr(wrap_clr), .wrap_flag(flag3),
`endif
        .cnt(cnt3), .tc(tc3), .wrap(wrap3)
    );

    function automatic exp_t mk(input int c, input bit t, input bit w, input bit f);
        exp_t e;
        e.cnt  = 4'(c);
        e.tc   = t;
        e.wrap = w;
        e.flag = f;
        return e;
    endfunction

    task automatic cmp(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick(input logic r, input logic l, input logic e, input logic u,
                        input logic s, input logic wc, input logic [3:0] lv);
        @(negedge clk);
        reset    = r;
        load     = l;
        en       = e;
        up       = u;
        sat      = s;
        load_val = lv;
`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
        wrap_clr = wc;
`else
        if (wc) begin end
`endif
        @(posedge clk);
    endtask

    // Monitor: compare the response of every scored edge, just after that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("d1.cnt", int'(cnt1), int'(e.cnt));
                cmp("d1.tc", int'(tc1), int'(e.tc));
                cmp("d1.wrap", int'(wrap1), int'(e.wrap));
`ifdef UPDOWN_COUNT_WRAP_FLAG_EN
                cmp("d1.wrap_flag", int'(flag1), int'(e.flag));
`endif
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                cmp("d3.cnt", int'(cnt3), int'(e.cnt));
                cmp("d3.tc", int'(tc3), int'(e.tc));
                cmp("d3.wrap", int'(wrap3), int'(e.wrap));
            end
        end
    end

    initial begin
        int c;
        // reset state, tc follows up
        tick(1, 0, 0, 0, 0, 0, 0); q1.push_back(mk(0, 1, 0, 0)); q3.push_back(mk(0, 1, 0, 0));
        tick(1, 0, 1, 1, 0, 0, 0); q1.push_back(mk(0, 0, 0, 0)); q3.push_back(mk(0, 0, 0, 0));

        // up-count wrap 0..9 -> 0
        for (int i = 1; i <= 11; i++) begin
            tick(0, 0, 1, 1, 0, 0, 0);
            c = i % 10;
            q1.push_back(mk(c, c == 9, i == 10, i >= 10));
        end
        tick(0, 0, 0, 1, 0, 1, 0); q1.push_back(mk(1, 0, 0, 0));

        // saturation down and up
        tick(0, 1, 1, 0, 1, 0, 2); q1.push_back(mk(2, 0, 0, 0));
        tick(0, 0, 1, 0, 1, 0, 0); q1.push_back(mk(1, 0, 0, 0));
        tick(0, 0, 1, 0, 1, 0, 0); q1.push_back(mk(0, 1, 0, 0));
        tick(0, 0, 1, 0, 1, 0, 0); q1.push_back(mk(0, 1, 0, 0));
        tick(0, 0, 1, 0, 1, 0, 0); q1.push_back(mk(0, 1, 0, 0));
        tick(0, 1, 1, 1, 1, 0, 8); q1.push_back(mk(8, 0, 0, 0));
        tick(0, 0, 1, 1, 1, 0, 0); q1.push_back(mk(9, 1, 0, 0));
        tick(0, 0, 1, 1, 1, 0, 0); q1.push_back(mk(9, 1, 0, 0));

        // load clamp, reset over load
        tick(0, 1, 1, 1, 0, 0, 14); q1.push_back(mk(9, 1, 0, 0)); q3.push_back(mk(9, 1, 0, 0));
        tick(1, 1, 1, 1, 0, 0, 5);  q1.push_back(mk(0, 0, 0, 0)); q3.push_back(mk(0, 0, 0, 0));

        // down wrap, sticky flag, set beats clear
        tick(0, 0, 1, 0, 0, 0, 0); q1.push_back(mk(9, 0, 1, 1));
        tick(0, 0, 0, 0, 0, 0, 0); q1.push_back(mk(9, 0, 0, 1));
        tick(0, 0, 0, 0, 0, 1, 0); q1.push_back(mk(9, 0, 0, 0));
        tick(0, 0, 1, 1, 0, 1, 0); q1.push_back(mk(0, 0, 1, 1));

        // prescale by 3, en gap stretches the step
        tick(1, 0, 1, 1, 0, 0, 0); q3.push_back(mk(0, 0, 0, 0));
        for (int i = 0; i < 11; i++) begin
            tick(0, 0, logic'(en_seq[i]), 1, 0, 0, 0);
            q3.push_back(mk(int'(cnt_seq[i]), 0, 0, 0));
        end

        // reset mid-prescale discards partial count
        tick(0, 1, 1, 1, 0, 0, 5); q3.push_back(mk(5, 0, 0, 0));
        tick(0, 0, 1, 1, 0, 0, 0); q3.push_back(mk(5, 0, 0, 0));
        tick(1, 0, 1, 1, 0, 0, 0); q3.push_back(mk(0, 0, 0, 0));
        tick(0, 0, 1, 1, 0, 0, 0); q3.push_back(mk(0, 0, 0, 0));
        tick(0, 0, 1, 1, 0, 0, 0); q3.push_back(mk(0, 0, 0, 0));
        tick(0, 0, 1, 1, 0, 0, 0); q3.push_back(mk(1, 0, 0, 0));

        // prescaled down wrap
        tick(0, 1, 1, 0, 0, 0, 0); q3.push_back(mk(0, 1, 0, 0));
        tick(0, 0, 1, 0, 0, 0, 0); q3.push_back(mk(0, 1, 0, 0));
        tick(0, 0, 1, 0, 0, 0, 0); q3.push_back(mk(0, 1, 0, 0));
        tick(0, 0, 1, 0, 0, 0, 0); q3.push_back(mk(9, 0, 1, 0));
        tick(0, 0, 1, 0, 0, 0, 0); q3.push_back(mk(9, 0, 0, 0));

        tick(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        cmp("scoreboard_drained", q1.size() + q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
